// File: rtl/rr_interval_classifier.sv
// R-R interval measurement and rhythm classification between accepted R-peak events.
// Emits a one-cycle rr_valid strobe with the interval, running average and live flags.
module rr_interval_classifier #(
  parameter int CNT_W      = 12,
  parameter int REFRACT_MS = 200,
  parameter int TACHY_MS   = 600,
  parameter int BRADY_MS   = 1000,
  parameter int TIMEOUT_MS = 3000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_ms,
  input  logic             beat,
  output logic             rr_valid,
  output logic [CNT_W-1:0] rr_ms,
  output logic [CNT_W-1:0] rr_avg,
  output logic             live_brady,
  output logic             live_tachy,
  output logic             live_irreg,
  output logic             live_normal
);

  localparam logic [CNT_W-1:0] REFRACT_C      = CNT_W'(REFRACT_MS);
  localparam logic [CNT_W-1:0] TACHY_C        = CNT_W'(TACHY_MS);
  localparam logic [CNT_W-1:0] BRADY_C        = CNT_W'(BRADY_MS);
  localparam logic [CNT_W-1:0] TIMEOUT_C      = CNT_W'(TIMEOUT_MS);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST_C = CNT_W'(TIMEOUT_MS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       n_int_q, n_int_d;
  logic             beat_prev_q, beat_prev_d;
  logic             rr_valid_q, rr_valid_d;
  logic [CNT_W-1:0] rr_ms_q, rr_ms_d;
  logic [CNT_W-1:0] rr_avg_q, rr_avg_d;
  logic             brady_q, brady_d;
  logic             tachy_q, tachy_d;
  logic             irreg_q, irreg_d;
  logic             normal_q, normal_d;

  logic                    beat_evt_s;
  logic                    brady_s;
  logic                    tachy_s;
  logic                    irreg_s;
  logic [CNT_W:0]          dev_s;
  logic signed [CNT_W:0]   delta_s;
  logic signed [CNT_W:0]   avg_sum_s;
  logic [CNT_W-1:0]        avg_next_s;

  // Classification and average arithmetic on the candidate interval (the current count).
  always_comb begin
    beat_evt_s = beat & ~beat_prev_q;
    brady_s    = (cnt_q > BRADY_C);
    tachy_s    = (cnt_q < TACHY_C);
    dev_s      = (cnt_q >= rr_avg_q) ? ({1'b0, cnt_q} - {1'b0, rr_avg_q})
                                     : ({1'b0, rr_avg_q} - {1'b0, cnt_q});
    irreg_s    = (n_int_q >= 3'd4) && (dev_s > {1'b0, (rr_avg_q >> 3)});
    delta_s    = $signed({1'b0, cnt_q}) - $signed({1'b0, rr_avg_q});
    avg_sum_s  = $signed({1'b0, rr_avg_q}) + (delta_s >>> 2);
    avg_next_s = (n_int_q == 3'd0) ? cnt_q : avg_sum_s[CNT_W-1:0];
  end

  // Next-state: arming, interval counting, acceptance and timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_int_d     = n_int_q;
    beat_prev_d = beat;
    rr_valid_d  = 1'b0;
    rr_ms_d     = rr_ms_q;
    rr_avg_d    = rr_avg_q;
    brady_d     = brady_q;
    tachy_d     = tachy_q;
    irreg_d     = irreg_q;
    normal_d    = normal_q;
    case (state_q)
      ST_IDLE: begin
        if (beat_evt_s) begin
          state_d = ST_ARMED;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d   = cnt_q;
        end
      end
      ST_ARMED: begin
        // A beat wins over a coincident timeout tick; refractory beats fall through to counting.
        if (beat_evt_s && (cnt_q >= REFRACT_C)) begin
          cnt_d      = {CNT_W{1'b0}};
          rr_valid_d = 1'b1;
          rr_ms_d    = cnt_q;
          rr_avg_d   = avg_next_s;
          brady_d    = brady_s;
          tachy_d    = tachy_s;
          irreg_d    = irreg_s;
          normal_d   = ~brady_s & ~tachy_s & ~irreg_s;
          n_int_d    = (n_int_q < 3'd4) ? (n_int_q + 3'd1) : n_int_q;
        end else if (tick_ms && (cnt_q == TIMEOUT_LAST_C)) begin
          state_d    = ST_IDLE;
          cnt_d      = {CNT_W{1'b0}};
          n_int_d    = 3'd0;
          rr_valid_d = 1'b1;
          rr_ms_d    = TIMEOUT_C;
          brady_d    = 1'b1;
          tachy_d    = 1'b0;
          irreg_d    = 1'b0;
          normal_d   = 1'b0;
        end else if (tick_ms) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
        n_int_d = 3'd0;
      end
    endcase
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      n_int_q     <= 3'd0;
      beat_prev_q <= 1'b0;
      rr_valid_q  <= 1'b0;
      rr_ms_q     <= {CNT_W{1'b0}};
      rr_avg_q    <= {CNT_W{1'b0}};
      brady_q     <= 1'b0;
      tachy_q     <= 1'b0;
      irreg_q     <= 1'b0;
      normal_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_int_q     <= n_int_d;
      beat_prev_q <= beat_prev_d;
      rr_valid_q  <= rr_valid_d;
      rr_ms_q     <= rr_ms_d;
      rr_avg_q    <= rr_avg_d;
      brady_q     <= brady_d;
      tachy_q     <= tachy_d;
      irreg_q     <= irreg_d;
      normal_q    <= normal_d;
    end
  end

  assign rr_valid    = rr_valid_q;
  assign rr_ms       = rr_ms_q;
  assign rr_avg      = rr_avg_q;
  assign live_brady  = brady_q;
  assign live_tachy  = tachy_q;
  assign live_irreg  = irreg_q;
  assign live_normal = normal_q;

endmodule

// File: tb/tb_rr_interval_classifier.sv
// Directed bench for rr_interval_classifier: hand-computed intervals, averages and flags.
// Ticks are one cycle high, one low, so each ms spans two clocks.
module tb_rr_interval_classifier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_ms = 1'b0;
  logic        beat = 1'b0;
  logic        rr_valid;
  logic [11:0] rr_ms;
  logic [11:0] rr_avg;
  logic        live_brady;
  logic        live_tachy;
  logic        live_irreg;
  logic        live_normal;

  int total = 0;
  int bad   = 0;

  rr_interval_classifier dut (
    .clk        (clk),
    .rst        (rst),
    .tick_ms    (tick_ms),
    .beat       (beat),
    .rr_valid   (rr_valid),
    .rr_ms      (rr_ms),
    .rr_avg     (rr_avg),
    .live_brady (live_brady),
    .live_tachy (live_tachy),
    .live_irreg (live_irreg),
    .live_normal(live_normal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick_ms = 1'b1;
      step();
      tick_ms = 1'b0;
      step();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Beat rising edge that must not produce a strobe (arming or refractory).
  task automatic quiet_beat(input string tag);
    beat = 1'b1;
    step();
    chk({tag, "_nostrobe"}, 16'(rr_valid), 16'd0);
    beat = 1'b0;
    step();
    chk({tag, "_nostrobe2"}, 16'(rr_valid), 16'd0);
  endtask

  // Beat that must produce a strobe; flags = {brady, tachy, irreg, normal}.
  task automatic strobe_beat(input string tag, input logic with_tick, input logic [11:0] exp_rr,
                             input logic [11:0] exp_avg, input logic [3:0] exp_flags);
    beat    = 1'b1;
    tick_ms = with_tick;
    step();
    chk({tag, "_valid"}, 16'(rr_valid), 16'd1);
    chk({tag, "_rr"}, 16'(rr_ms), 16'(exp_rr));
    chk({tag, "_avg"}, 16'(rr_avg), 16'(exp_avg));
    chk({tag, "_flags"}, 16'({live_brady, live_tachy, live_irreg, live_normal}), 16'(exp_flags));
    beat    = 1'b0;
    tick_ms = 1'b0;
    step();
    chk({tag, "_pulse"}, 16'(rr_valid), 16'd0);
    chk({tag, "_hold"}, 16'(rr_ms), 16'(exp_rr));
  endtask

  initial begin
    do_reset();
    chk("rst_valid", 16'(rr_valid), 16'd0);
    chk("rst_rr", 16'(rr_ms), 16'd0);
    chk("rst_avg", 16'(rr_avg), 16'd0);
    chk("rst_flags", 16'({live_brady, live_tachy, live_irreg, live_normal}), 16'd0);

    // Steady 800 ms rhythm.
    quiet_beat("t1_arm");
    for (int k = 0; k < 5; k++) begin
      tick_n(800);
      strobe_beat("t1_800", 1'b0, 12'd800, 12'd800, 4'b0001);
    end

    // Brady then tachy; -700 >>> 2 = -175.
    do_reset();
    quiet_beat("t2_arm");
    tick_n(1200);
    strobe_beat("t2_1200", 1'b0, 12'd1200, 12'd1200, 4'b1000);
    tick_n(500);
    strobe_beat("t2_500", 1'b0, 12'd500, 12'd1025, 4'b0100);

    // Irregular after four steady intervals: |200| > 100, avg 800 + 50.
    do_reset();
    quiet_beat("t3_arm");
    for (int k = 0; k < 4; k++) begin
      tick_n(800);
      strobe_beat("t3_800", 1'b0, 12'd800, 12'd800, 4'b0001);
    end
    tick_n(1000);
    strobe_beat("t3_1000", 1'b0, 12'd1000, 12'd850, 4'b0010);

    // Refractory beat at 150 ms is ignored; interval keeps counting to 800.
    do_reset();
    quiet_beat("t4_arm");
    tick_n(150);
    quiet_beat("t4_refr");
    tick_n(650);
    strobe_beat("t4_800", 1'b0, 12'd800, 12'd800, 4'b0001);

    // Timeout exactly on the 3000th tick; average held, then IDLE ignores ticks.
    tick_n(2999);
    chk("t5_pre_timeout", 16'(rr_valid), 16'd0);
    tick_ms = 1'b1;
    step();
    tick_ms = 1'b0;
    chk("t5_to_valid", 16'(rr_valid), 16'd1);
    chk("t5_to_rr", 16'(rr_ms), 16'd3000);
    chk("t5_to_avg", 16'(rr_avg), 16'd800);
    chk("t5_to_flags", 16'({live_brady, live_tachy, live_irreg, live_normal}), 16'b1000);
    step();
    chk("t5_to_pulse", 16'(rr_valid), 16'd0);
    tick_n(50);
    quiet_beat("t5_rearm");
    tick_n(700);
    strobe_beat("t5_700", 1'b0, 12'd700, 12'd700, 4'b0001);

    // Reset mid-interval clears outputs; next beat only arms.
    tick_n(400);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_valid", 16'(rr_valid), 16'd0);
    chk("t6_rst_rr", 16'(rr_ms), 16'd0);
    chk("t6_rst_avg", 16'(rr_avg), 16'd0);
    chk("t6_rst_flags", 16'({live_brady, live_tachy, live_irreg, live_normal}), 16'd0);
    quiet_beat("t6_arm");
    // Beat coincident with a tick reports the pre-tick count.
    tick_n(700);
    strobe_beat("t6_tickbeat", 1'b1, 12'd700, 12'd700, 4'b0001);
    // Exactly at the refractory bound is accepted: 700 + (-500 >>> 2) = 575.
    tick_n(200);
    strobe_beat("t6_refr_edge", 1'b0, 12'd200, 12'd575, 4'b0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
